id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the pipelined RISC core; captures decoded fields from ID and presents them to EX.
- Its outputs feed the ALU control decoder (ALUop, func7, func3) and the ALU operand muxes.
- Contains load-use hazard detection: it requests an ID/IF hold and inserts a bubble into EX.

Parameters:
- XLEN, 32, operand/immediate/PC width
- RA_W, 5, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands / immediate
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1 / rs2
- id_ALUop  in  3  ALU op class from main control
- id_func7  in  7;  id_func3  in  3  instruction fields
- id_ctrl  in  5  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc}
- stall  in  1  downstream hold: EX contents frozen
- flush  in  1  branch/jump redirect: kill EX contents
- ex_valid  out  1;  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN
- ex_rs1, ex_rs2, ex_rd  out  RA_W;  ex_ALUop  out  3;  ex_func7  out  7;  ex_func3  out  3;  ex_ctrl  out  5
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset:
  - All registered outputs are 0, including ex_valid=0, ex_ctrl=0, ex_ALUop=000.
  - hazard_stall=0 while rst=1.
- Bubble value:
  - Every registered field is 0.
  - Downstream decodes ALUop=000 as add; the bubble has no side effects because RegWrite=MemWrite=MemRead=0.
- Load-use detect (combinational):
  - hazard_stall = ex_valid & ex_ctrl.MemRead & (ex_rd!=0) & id_valid & !flush & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Reading x0 never raises hazard_stall.
- Per-edge update priority, highest first:
  - rst: load reset values.
  - flush: load the bubble, whether or not stall is asserted.
  - stall: hold every register unchanged. While stall=1, hazard_stall is still computed; the bubble is deferred until stall falls.
  - hazard_stall: load the bubble. ID keeps its instruction; the external PC/IF-ID hold is driven by hazard_stall.
  - otherwise: load all id_* fields, and set ex_valid=id_valid.
- Latency: 1 cycle ID→EX. Back-to-back loading is supported at full rate.
- The hazard resolves itself after one bubble: once the load advances, ex_valid=0 or ex_ctrl.MemRead=0, so hazard_stall falls.
- id_valid=0 with no stall/flush loads a bubble-equivalent entry: id_* data passes through, ex_valid=0, and ex_ctrl is forced to 0.
- A reset asserted mid-stall or mid-hazard wins unconditionally. No pending state exists beyond these registers.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined:
  - Adds output bubble_cnt[31:0] and output stall_cnt[31:0].
  - bubble_cnt increments on each edge that loads a bubble due to hazard_stall.
  - stall_cnt increments on each edge with stall=1 and no rst/flush.
  - Both reset to 0, wrap at 2^32, and are unaffected by flush.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package core_pkg:
  - ctrl bit indices REGWRITE=4, MEMREAD=3, MEMWRITE=2, MEMTOREG=1, ALUSRC=0.
  - ALUop encodings: 000 add, 001 I-type, 010 branch-sub, 110 sub-class, plus the R-type value.
  - XLEN/RA_W defaults.
- One sub-module: load_use_detect. It is purely combinational and produces hazard_stall; it is instantiated once.

Test Plan:
- Reset → all outputs 0, hazard_stall=0. Then release rst and drive id_valid=1, id_ALUop=001, id_func3=110, id_rd=5 → next edge ex_ALUop=001, ex_func3=110, ex_rd=5, ex_valid=1.
- Load-use: EX holds MemRead=1, rd=7; ID id_rs2=7, id_use_rs2=1 → hazard_stall=1, next edge bubble in EX (ex_ctrl=0, ex_valid=0); following cycle hazard_stall=0, ID instruction loads.
- x0 / unused operand:
  - EX load with rd=0 and ID rs1=0 → hazard_stall=0.
  - EX load rd=9 and ID rs1=9 with id_use_rs1=0 → hazard_stall=0.
- stall=1 for 3 cycles with changing id_* → ex_* constant. Then flush=1 with stall=1 → bubble loaded.
- flush concurrent with a hazard condition → hazard_stall=0, bubble loaded, ID not held.
- ID_EX_PERF_EN:
  - One hazard plus 3 stall cycles → bubble_cnt=1, stall_cnt=3.
  - Preload near wrap (0xFFFFFFFF) plus 1 more hazard → bubble_cnt=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipelined RISC core: default widths, id_ctrl bit
// positions, ALU op-class encodings and a small control-decode helper.
package core_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;
    localparam int CTRL_W   = 5;

    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_ALUSRC   = 0;

    typedef enum logic [2:0] {
        ALUOP_ADD    = 3'b000,
        ALUOP_ITYPE  = 3'b001,
        ALUOP_BRANCH = 3'b010,
        ALUOP_RTYPE  = 3'b100,
        ALUOP_SUBCLS = 3'b110
    } aluop_e;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 5'b00000;

    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: raises hazard_stall when the load in
// EX writes a register that the instruction in ID actually reads.
module load_use_detect
    import core_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            id_valid,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            flush,
    output logic            hazard_stall
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Operand match against the EX destination; x0 is never a real producer.
    always_comb begin
        rs1_hit_s    = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit_s    = id_use_rs2 && (id_rs2 == ex_rd);
        hazard_stall = !rst && ex_valid && ex_memread && (ex_rd != {RA_W{1'b0}})
                       && id_valid && !flush && (rs1_hit_s || rs2_hit_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional ID_EX_PERF_EN adds bubble_cnt/stall_cnt performance counters.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [2:0]        id_ALUop,
    input  logic [6:0]        id_func7,
    input  logic [2:0]        id_func3,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic [RA_W-1:0]   ex_rd,
    output logic [2:0]        ex_ALUop,
    output logic [6:0]        ex_func7,
    output logic [2:0]        ex_func3,
    output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              hazard_stall
);

    logic              ex_valid_d, ex_valid_q;
    logic [XLEN-1:0]   ex_pc_d, ex_pc_q;
    logic [XLEN-1:0]   ex_rs1_data_d, ex_rs1_data_q;
    logic [XLEN-1:0]   ex_rs2_data_d, ex_rs2_data_q;
    logic [XLEN-1:0]   ex_imm_d, ex_imm_q;
    logic [RA_W-1:0]   ex_rs1_d, ex_rs1_q;
    logic [RA_W-1:0]   ex_rs2_d, ex_rs2_q;
    logic [RA_W-1:0]   ex_rd_d, ex_rd_q;
    logic [2:0]        ex_aluop_d, ex_aluop_q;
    logic [6:0]        ex_func7_d, ex_func7_q;
    logic [2:0]        ex_func3_d, ex_func3_q;
    logic [CTRL_W-1:0] ex_ctrl_d, ex_ctrl_q;
    logic              bubble_s;

    load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
        .rst          (rst),
        .ex_valid     (ex_valid_q),
        .ex_memread   (is_load(ex_ctrl_q)),
        .ex_rd        (ex_rd_q),
        .id_valid     (id_valid),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .flush        (flush),
        .hazard_stall (hazard_stall)
    );

    // Flush beats stall; a pending hazard bubble waits until stall drops.
    assign bubble_s = flush || (!stall && hazard_stall);

    // Next-state selection: bubble, hold, or capture from ID.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_aluop_d    = ex_aluop_q;
        ex_func7_d    = ex_func7_q;
        ex_func3_d    = ex_func3_q;
        ex_ctrl_d     = ex_ctrl_q;
        if (bubble_s) begin
            ex_valid_d    = 1'b0;
            ex_pc_d       = {XLEN{1'b0}};
            ex_rs1_data_d = {XLEN{1'b0}};
            ex_rs2_data_d = {XLEN{1'b0}};
            ex_imm_d      = {XLEN{1'b0}};
            ex_rs1_d      = {RA_W{1'b0}};
            ex_rs2_d      = {RA_W{1'b0}};
            ex_rd_d       = {RA_W{1'b0}};
            ex_aluop_d    = ALUOP_ADD;
            ex_func7_d    = 7'd0;
            ex_func3_d    = 3'd0;
            ex_ctrl_d     = CTRL_BUBBLE;
        end else if (!stall) begin
            ex_valid_d    = id_valid;
            ex_pc_d       = id_pc;
            ex_rs1_data_d = id_rs1_data;
            ex_rs2_data_d = id_rs2_data;
            ex_imm_d      = id_imm;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
            ex_rd_d       = id_rd;
            ex_aluop_d    = id_ALUop;
            ex_func7_d    = id_func7;
            ex_func3_d    = id_func3;
            // An empty ID slot must not carry side effects into EX.
            ex_ctrl_d     = id_valid ? id_ctrl : CTRL_BUBBLE;
        end else begin
            ex_valid_d    = ex_valid_q;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= {XLEN{1'b0}};
            ex_rs1_data_q <= {XLEN{1'b0}};
            ex_rs2_data_q <= {XLEN{1'b0}};
            ex_imm_q      <= {XLEN{1'b0}};
            ex_rs1_q      <= {RA_W{1'b0}};
            ex_rs2_q      <= {RA_W{1'b0}};
            ex_rd_q       <= {RA_W{1'b0}};
            ex_aluop_q    <= 3'd0;
            ex_func7_q    <= 7'd0;
            ex_func3_q    <= 3'd0;
            ex_ctrl_q     <= CTRL_BUBBLE;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_func7_q    <= ex_func7_d;
            ex_func3_q    <= ex_func3_d;
            ex_ctrl_q     <= ex_ctrl_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_ALUop    = ex_aluop_q;
    assign ex_func7    = ex_func7_q;
    assign ex_func3    = ex_func3_q;
    assign ex_ctrl     = ex_ctrl_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Counters ignore flush; only hazard bubbles and genuine stall cycles count.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {31'd0, (!flush && !stall && hazard_stall)};
        stall_cnt_d  = stall_cnt_q + {31'd0, (stall && !flush)};
    end

    // Counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then randomized traffic
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [2:0]  aluop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  ctrl;
        logic        stall, flush;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  aluop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  ctrl;
`ifdef ID_EX_PERF_EN
        logic [31:0] bcnt, scnt;
`endif
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_use_rs1, id_use_rs2, stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_ctrl;
    logic [2:0]  id_ALUop, id_func3;
    logic [6:0]  id_func7;
    logic        ex_valid, hazard_stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_ctrl;
    logic [2:0]  ex_ALUop, ex_func3;
    logic [6:0]  ex_func7;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    ex_t  m;
    ex_t  ex_q[$];
    bit   hz_q[$];
    bit   last_hz = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ALUop(id_ALUop),
        .id_func7(id_func7), .id_func3(id_func3), .id_ctrl(id_ctrl),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ALUop(ex_ALUop),
        .ex_func7(ex_func7), .ex_func3(ex_func3), .ex_ctrl(ex_ctrl),
`ifdef ID_EX_PERF_EN
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
        .hazard_stall(hazard_stall)
    );

    // Reference: a load in EX blocks any younger ID instruction that reads its rd.
    function automatic bit model_hazard(ex_t c, stim_t s);
        bit reads_rd;
        reads_rd = (s.use1 && s.rs1 == c.rd) || (s.use2 && s.rs2 == c.rd);
        return !s.rst && c.valid && c.ctrl[3] && (c.rd != 5'd0) && s.valid && !s.flush && reads_rd;
    endfunction

    function automatic ex_t model_next(ex_t c, stim_t s, bit h);
        ex_t n;
        n = c;
`ifdef ID_EX_PERF_EN
        if (s.rst) begin
            n.bcnt = 32'd0;
            n.scnt = 32'd0;
        end else begin
            if (!s.flush && s.stall) n.scnt = c.scnt + 32'd1;
            if (!s.flush && !s.stall && h) n.bcnt = c.bcnt + 32'd1;
        end
`endif
        if (s.rst || s.flush || (!s.stall && h)) begin
`ifdef ID_EX_PERF_EN
            n = '{valid: 1'b0, pc: 32'd0, rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0,
                  rd: 5'd0, aluop: 3'd0, f7: 7'd0, f3: 3'd0, ctrl: 5'd0, bcnt: n.bcnt, scnt: n.scnt};
`else
            n = '0;
`endif
        end else if (!s.stall) begin
            n.valid = s.valid;  n.pc = s.pc;  n.rs1d = s.rs1d;  n.rs2d = s.rs2d;  n.imm = s.imm;
            n.rs1 = s.rs1;  n.rs2 = s.rs2;  n.rd = s.rd;  n.aluop = s.aluop;  n.f7 = s.f7;  n.f3 = s.f3;
            n.ctrl = s.valid ? s.ctrl : 5'd0;
        end
        return n;
    endfunction

    task automatic step(input stim_t s);
        bit h;
        @(posedge clk);
        #2;
        rst = s.rst;  id_valid = s.valid;  id_pc = s.pc;  id_rs1_data = s.rs1d;
        id_rs2_data = s.rs2d;  id_imm = s.imm;  id_rs1 = s.rs1;  id_rs2 = s.rs2;  id_rd = s.rd;
        id_use_rs1 = s.use1;  id_use_rs2 = s.use2;  id_ALUop = s.aluop;  id_func7 = s.f7;
        id_func3 = s.f3;  id_ctrl = s.ctrl;  stall = s.stall;  flush = s.flush;
        h = model_hazard(m, s);
        hz_q.push_back(h);
        m = model_next(m, s, h);
        ex_q.push_back(m);
        last_hz = h;
    endtask

    function automatic stim_t rand_instr();
        stim_t s;
        s = '0;
        s.valid = ($urandom_range(0, 9) < 8);
        s.pc = $urandom;  s.rs1d = $urandom;  s.rs2d = $urandom;  s.imm = $urandom;
        s.rs1 = 5'($urandom_range(0, 3));  s.rs2 = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.use1 = 1'($urandom);  s.use2 = 1'($urandom);
        s.aluop = 3'($urandom);  s.f7 = 7'($urandom);  s.f3 = 3'($urandom);  s.ctrl = 5'($urandom);
        return s;
    endfunction

    function automatic stim_t load_to(input logic [4:0] rd);
        stim_t s;
        s = '0;
        s.valid = 1'b1;  s.rd = rd;  s.ctrl = 5'b01011;  s.pc = 32'h100;  s.imm = 32'h10;
        return s;
    endfunction

    // Monitor: EX contents just after each edge, hazard_stall mid-cycle.
    initial begin
        ex_t act, exp_ex;
        bit  exp_hz;
        forever begin
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                exp_ex = ex_q.pop_front();
                act.valid = ex_valid;  act.pc = ex_pc;  act.rs1d = ex_rs1_data;  act.rs2d = ex_rs2_data;
                act.imm = ex_imm;  act.rs1 = ex_rs1;  act.rs2 = ex_rs2;  act.rd = ex_rd;
                act.aluop = ex_ALUop;  act.f7 = ex_func7;  act.f3 = ex_func3;  act.ctrl = ex_ctrl;
`ifdef ID_EX_PERF_EN
                act.bcnt = bubble_cnt;  act.scnt = stall_cnt;
`endif
                n_cmp++;
                if (act !== exp_ex) begin
                    n_bad++;
                    $display("FAIL ex_state t=%0t got=%h exp=%h", $time, act, exp_ex);
                end
            end
            @(negedge clk);
            if (hz_q.size() > 0) begin
                exp_hz = hz_q.pop_front();
                n_cmp++;
                if (hazard_stall !== exp_hz) begin
                    n_bad++;
                    $display("FAIL hazard_stall t=%0t got=%b exp=%b", $time, hazard_stall, exp_hz);
                end
            end
        end
    end

    initial begin
        stim_t s, cur;
        m = '0;
        s = '0;
        rst = 1'b1;  id_valid = 1'b0;  id_pc = 32'd0;  id_rs1_data = 32'd0;  id_rs2_data = 32'd0;
        id_imm = 32'd0;  id_rs1 = 5'd0;  id_rs2 = 5'd0;  id_rd = 5'd0;  id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;  id_ALUop = 3'd0;  id_func7 = 7'd0;  id_func3 = 3'd0;  id_ctrl = 5'd0;
        stall = 1'b0;  flush = 1'b0;

        s.rst = 1'b1;  step(s);  step(s);
        s = '0;  s.valid = 1'b1;  s.aluop = 3'b001;  s.f3 = 3'b110;  s.rd = 5'd5;  step(s);

        // Load-use on rs2, then the held instruction issues.
        step(load_to(5'd7));
        s = '0;  s.valid = 1'b1;  s.rs2 = 5'd7;  s.use2 = 1'b1;  s.rd = 5'd8;  s.ctrl = 5'b10000;
        s.pc = 32'h104;  step(s);  step(s);

        // x0 and unused-operand cases never stall.
        step(load_to(5'd0));
        s = '0;  s.valid = 1'b1;  s.use1 = 1'b1;  step(s);
        step(load_to(5'd9));
        s = '0;  s.valid = 1'b1;  s.rs1 = 5'd9;  s.rs2 = 5'd3;  s.use2 = 1'b1;  step(s);

        // Downstream stall freezes EX; flush under stall still bubbles.
        for (int i = 0; i < 3; i++) begin
            s = rand_instr();  s.stall = 1'b1;  step(s);
        end
        s = rand_instr();  s.stall = 1'b1;  s.flush = 1'b1;  step(s);

        // Flush concurrent with a hazard condition.
        step(load_to(5'd4));
        s = '0;  s.valid = 1'b1;  s.rs1 = 5'd4;  s.use1 = 1'b1;  s.flush = 1'b1;  step(s);

        // One hazard bubble plus three stall cycles after a fresh reset.
        s = '0;  s.rst = 1'b1;  step(s);
        step(load_to(5'd6));
        s = '0;  s.valid = 1'b1;  s.rs1 = 5'd6;  s.use1 = 1'b1;  step(s);  step(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_instr();  s.stall = 1'b1;  step(s);
        end
        s = '0;  step(s);

        // Random traffic; ID keeps its instruction while held.
        cur = rand_instr();
        for (int i = 0; i < 2000; i++) begin
            if (!(last_hz || cur.stall)) cur = rand_instr();
            cur.stall = ($urandom_range(0, 99) < 15);
            cur.flush = ($urandom_range(0, 99) < 8);
            cur.rst   = ($urandom_range(0, 99) < 2);
            step(cur);
        end
        s = '0;  step(s);  step(s);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
